// File: rtl/bch_err_collect_if.sv
// Handshake bundle between the BCH decoder / consumer and bch_err_collect.
// The master side drives frame start, error locations and out_ready; the slave side is the collector.
interface bch_err_collect_if;
    logic       set;
    logic [1:0] code;
    logic       in_valid;
    logic [9:0] in_loc;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_loc;
    logic       out_last;
    logic [3:0] cnt;
    logic       ovf;
    logic       done;
    logic       busy;

    modport master (
        output set, code, in_valid, in_loc, out_ready,
        input  out_valid, out_loc, out_last, cnt, ovf, done, busy
    );

    modport slave (
        input  set, code, in_valid, in_loc, out_ready,
        output out_valid, out_loc, out_last, cnt, ovf, done, busy
    );
endinterface

// File: rtl/bch_err_collect.sv
// Collects up to 8 BCH error locations per frame and drains them over a valid/ready port.
// Define BCH_COLL_SORT_EN to insert locations in ascending order instead of arrival order.
module bch_err_collect (
    input  logic              clk,
    input  logic              rstn,
    bch_err_collect_if.slave  bus
);

    localparam int DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       seen_q, seen_d;
    logic [9:0] buf_q [DEPTH];
    logic [9:0] buf_d [DEPTH];

    logic [9:0] n_lim;
    logic       in_range;
    logic       full;
    logic       accept;
    logic       drop;
    logic       pop;
    logic [3:0] ins_pos;

    // Code length for the latched code; 0 is reserved and behaves like code 1.
    always_comb begin
        case (code_q)
            2'd2:    n_lim = 10'd255;
            2'd3:    n_lim = 10'd1023;
            default: n_lim = 10'd63;
        endcase
    end

    assign in_range = bus.in_loc < n_lim;
    assign full     = cnt_q[3];
    assign accept   = (state_q == COLLECT) && bus.in_valid && in_range && !full;
    assign drop     = (state_q == COLLECT) && bus.in_valid && in_range &&  full;

    // Outputs are decoded from registers only, so out_ready never reaches out_valid.
    assign bus.out_valid = (state_q == DRAIN) && (cnt_q != 4'd0);
    assign bus.out_last  = bus.out_valid && (cnt_q == 4'd1);
    assign bus.out_loc   = buf_q[0];
    assign bus.cnt       = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.done      = (state_q == DRAIN) && (cnt_q == 4'd0);
    assign bus.busy      = (state_q != IDLE);

    assign pop = bus.out_valid && bus.out_ready;

`ifdef BCH_COLL_SORT_EN
    // First slot holding a strictly larger value; equal values stay ahead of the newcomer.
    always_comb begin
        ins_pos = cnt_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((4'(i) < cnt_q) && (buf_q[i] > bus.in_loc)) begin
                ins_pos = 4'(i);
            end
        end
    end
`else
    assign ins_pos = cnt_q;
`endif

    // Buffer update: clear on frame start, insert-with-shift on accept, shift-down on pop.
    // NOTE: every always_comb target gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_d[i] = buf_q[i];
        end
        if ((state_q == IDLE) && bus.set) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_d[i] = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (4'(i) == ins_pos) begin
                    buf_d[i] = bus.in_loc;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if ((4'(i) > ins_pos) && (4'(i) <= cnt_q)) begin
                    buf_d[i] = buf_q[i-1];
                end
            end
        end else if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                buf_d[i] = buf_q[i+1];
            end
            buf_d[DEPTH-1] = '0;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (bus.set) begin
                    state_d = COLLECT;
                    code_d  = bus.code;
                    cnt_d   = 4'd0;
                    ovf_d   = 1'b0;
                    seen_d  = 1'b0;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    seen_d = 1'b1;
                    if (accept) cnt_d = cnt_q + 4'd1;
                    if (drop)   ovf_d = 1'b1;
                end else if (seen_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else if (pop) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            code_q  <= 2'd1;
            cnt_q   <= 4'd0;
            ovf_q   <= 1'b0;
            seen_q  <= 1'b0;
            // NOTE: the buffer is a small register file, so it is cleared on reset and out_loc reads 0.
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            seen_q  <= seen_d;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bch_err_collect.sv
// Self-checking bench for bch_err_collect: table-driven frames plus hand-written reset/stall sequences.
// Expected drain order follows BCH_COLL_SORT_EN when the macro is defined.
module tb_bch_err_collect;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    bch_err_collect_if bus ();

    bch_err_collect dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;
        int nloc;
        int locs[10];
        int ecnt;
        int eovf;
        int nout;
        int outs[8];
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full frame: set, feed locations, drain with out_ready=1, expect done and return to IDLE.
    task automatic run_frame(input int idx);
        vec_t v;
        v = vecs[idx];
        bus.set = 1'b1;
        bus.code = 2'(v.code);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.set = 1'b0;
        check($sformatf("v%0d busy_collect", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d ovf_clear", idx), 32'(bus.ovf), 32'd0);
        for (int k = 0; k < v.nloc; k++) begin
            bus.in_valid = 1'b1;
            bus.in_loc = 10'(v.locs[k]);
            tick();
        end
        bus.in_valid = 1'b0;
        check($sformatf("v%0d cnt", idx), 32'(bus.cnt), 32'(v.ecnt));
        check($sformatf("v%0d ovf", idx), 32'(bus.ovf), 32'(v.eovf));
        check($sformatf("v%0d no_out_in_collect", idx), 32'(bus.out_valid), 32'd0);
        tick();
        for (int j = 0; j < v.nout; j++) begin
            check($sformatf("v%0d out_valid[%0d]", idx, j), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d out_loc[%0d]", idx, j), 32'(bus.out_loc), 32'(v.outs[j]));
            check($sformatf("v%0d out_last[%0d]", idx, j), 32'(bus.out_last), 32'(j == v.nout - 1));
            check($sformatf("v%0d done_early[%0d]", idx, j), 32'(bus.done), 32'd0);
            tick();
        end
        check($sformatf("v%0d out_valid_end", idx), 32'(bus.out_valid), 32'd0);
        check($sformatf("v%0d done", idx), 32'(bus.done), 32'd1);
        tick();
        check($sformatf("v%0d done_one_cycle", idx), 32'(bus.done), 32'd0);
        check($sformatf("v%0d idle", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d ovf_sticky", idx), 32'(bus.ovf), 32'(v.eovf));
    endtask

    initial begin
        int stall_ready[5];
        int stall_loc[5];
        int xfers;

        n_cmp = 0;
        n_bad = 0;

        //             code nloc locs                                    cnt ovf nout outs
`ifdef BCH_COLL_SORT_EN
        vecs[0] = '{1, 3, '{40, 7, 1023, 0, 0, 0, 0, 0, 0, 0}, 2, 0, 2, '{7, 40, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{0, 3, '{62, 63, 5, 0, 0, 0, 0, 0, 0, 0},   2, 0, 2, '{5, 62, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{2, 4, '{254, 255, 3, 254, 0, 0, 0, 0, 0, 0}, 3, 0, 3, '{3, 254, 254, 0, 0, 0, 0, 0}};
`else
        vecs[0] = '{1, 3, '{40, 7, 1023, 0, 0, 0, 0, 0, 0, 0}, 2, 0, 2, '{40, 7, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{0, 3, '{62, 63, 5, 0, 0, 0, 0, 0, 0, 0},   2, 0, 2, '{62, 5, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{2, 4, '{254, 255, 3, 254, 0, 0, 0, 0, 0, 0}, 3, 0, 3, '{254, 3, 254, 0, 0, 0, 0, 0}};
`endif
        vecs[1] = '{2, 2, '{300, 12, 0, 0, 0, 0, 0, 0, 0, 0},  1, 0, 1, '{12, 0, 0, 0, 0, 0, 0, 0}};
        vecs[2] = '{3, 10, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9},    8, 1, 8, '{0, 1, 2, 3, 4, 5, 6, 7}};
        vecs[3] = '{1, 1, '{1023, 0, 0, 0, 0, 0, 0, 0, 0, 0},  0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};

        // Reset with set asserted in the same cycles: set must be ignored.
        rstn = 1'b0;
        bus.set = 1'b1;
        bus.code = 2'd3;
        bus.in_valid = 1'b0;
        bus.in_loc = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst cnt", 32'(bus.cnt), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_loc", 32'(bus.out_loc), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst ovf", 32'(bus.ovf), 32'd0);
        rstn = 1'b1;
        bus.set = 1'b0;
        tick();
        check("post_rst idle", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_frame(i);
        end

        // Idle cycles in COLLECT before the first location, then a stalled drain with set ignored.
        stall_ready = '{1, 0, 0, 1, 1};
        stall_loc   = '{100, 200, 200, 200, 300};
        bus.set = 1'b1;
        bus.code = 2'd3;
        tick();
        bus.set = 1'b0;
        tick();
        tick();
        check("pre_valid still collect", 32'(bus.busy), 32'd1);
        check("pre_valid no done", 32'(bus.done), 32'd0);
        check("pre_valid no out", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_loc = 10'(100 * (k + 1));
            tick();
        end
        bus.in_valid = 1'b0;
        check("stall cnt", 32'(bus.cnt), 32'd3);
        tick();
        xfers = 0;
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = stall_ready[c][0];
            bus.set = (c == 1);
            bus.code = 2'd1;
            check($sformatf("stall out_valid[%0d]", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall out_loc[%0d]", c), 32'(bus.out_loc), 32'(stall_loc[c]));
            check($sformatf("stall out_last[%0d]", c), 32'(bus.out_last), 32'(c == 4));
            if (bus.out_valid && bus.out_ready) xfers++;
            tick();
        end
        bus.set = 1'b0;
        check("stall xfers", 32'(xfers), 32'd3);
        check("stall done", 32'(bus.done), 32'd1);
        tick();
        check("stall idle after done", 32'(bus.busy), 32'd0);

        // Reset mid-COLLECT after two entries, with set and in_valid asserted during reset.
        bus.set = 1'b1;
        bus.code = 2'd2;
        tick();
        bus.set = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_loc = 10'd5;
        tick();
        bus.in_loc = 10'd6;
        tick();
        check("midrst cnt_before", 32'(bus.cnt), 32'd2);
        rstn = 1'b0;
        bus.set = 1'b1;
        bus.in_loc = 10'd7;
        tick();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst cnt", 32'(bus.cnt), 32'd0);
        check("midrst out_loc", 32'(bus.out_loc), 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst out_last", 32'(bus.out_last), 32'd0);
        check("midrst ovf", 32'(bus.ovf), 32'd0);
        rstn = 1'b1;
        bus.set = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("midrst set_ignored", 32'(bus.busy), 32'd0);
        run_frame(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
